// File: rtl/pwm_capture_average.sv
// pwm_capture_average
// Moving average of the last 2**K_LOG2_DEPTH PWM captures, with PWM-loss detection.
// Each accepted capture goes into a ring buffer. A running sum tracks the buffer
// contents, so the average is available one cycle after the capture.
// If no capture arrives within i_timeout timebase ticks, the block flushes and
// reports loss.
//
// Optional feature: define PWM_AVG_DROP_SATURATED_EN to reject all-ones (saturated)
// captures. A rejected capture still counts as proof of life for loss detection.
//
// state       | meaning
// ST_FILLING  | fewer than D samples held since last flush, o_valid low
// ST_FULL     | D samples held, o_valid high, average is meaningful
// ST_LOST     | no capture within timeout, everything flushed, o_timeout high

module pwm_capture_average #(
    parameter int K_DWIDTH     = 16,
    parameter int K_LOG2_DEPTH = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_timebase,
    input  logic                i_capture_done,
    input  logic [K_DWIDTH-1:0] i_capture_value,
    input  logic [K_DWIDTH-1:0] i_timeout,
    input  logic                i_clear,
    output logic [K_DWIDTH-1:0] o_value,
    output logic                o_update,
    output logic                o_valid,
    output logic                o_timeout
);

    localparam int D  = 1 << K_LOG2_DEPTH;
    localparam int SW = K_DWIDTH + K_LOG2_DEPTH;
    // Keep the pointer at least one bit wide so that depth 1 still elaborates.
    localparam int PW = (K_LOG2_DEPTH == 0) ? 1 : K_LOG2_DEPTH;
    localparam int FW = K_LOG2_DEPTH + 1;

    localparam logic [PW-1:0] WPTR_LAST = PW'(D - 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(D);

    typedef enum logic [1:0] {
        ST_FILLING = 2'd0,
        ST_FULL    = 2'd1,
        ST_LOST    = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [K_DWIDTH-1:0]   ring_q [D];
    logic [K_DWIDTH-1:0]   ring_d [D];
    logic [SW-1:0]         sum_q, sum_d;
    logic [FW-1:0]         fill_q, fill_d;
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [K_DWIDTH-1:0]   loss_q, loss_d;
    logic [K_DWIDTH-1:0]   value_q, value_d;
    logic                  update_q, update_d;
    logic                  valid_q, valid_d;
    logic                  timeout_q, timeout_d;

    logic                  sat;
    logic                  touch;
    logic                  accept;
    logic                  loss_hit;
    logic                  flush;
    logic [SW-1:0]         sum_new;
    logic [SW-1:0]         sum_shift;
    logic [FW-1:0]         fill_new;
    logic [K_DWIDTH-1:0]   loss_next;

`ifdef PWM_AVG_DROP_SATURATED_EN
    assign sat = (i_capture_value == {K_DWIDTH{1'b1}});
`else
    assign sat = 1'b0;
`endif

    // A capture (even a rejected one) is proof of life. Only unsaturated ones enter the average.
    assign touch  = i_capture_done & ~i_clear;
    assign accept = touch & ~sat;

    // The sum always equals the sum of the buffer entries, so it can never overflow.
    // Unwritten entries read as zero, so the same update holds while filling.
    assign sum_new   = sum_q + SW'(i_capture_value) - SW'(ring_q[wptr_q]);
    assign sum_shift = sum_new >> K_LOG2_DEPTH;
    assign fill_new  = (fill_q == FILL_FULL) ? fill_q : fill_q + FW'(1);

    // Loss counter: counts ticks that have no capture. It saturates at all-ones, so
    // a threshold lowered below the current count never fires.
    always_comb begin
        loss_next = loss_q;
        if (i_timeout == '0 || state_q == ST_LOST) begin
            loss_next = '0;
        end else if (i_timebase && loss_q != {K_DWIDTH{1'b1}}) begin
            loss_next = loss_q + K_DWIDTH'(1);
        end
    end

    assign loss_hit = ~touch && (i_timeout != '0) && (state_q != ST_LOST) && (loss_next == i_timeout);

    // Next-state logic. Priority order: clear, then a capture, then loss detection.
    always_comb begin
        state_d   = state_q;
        ring_d    = ring_q;
        sum_d     = sum_q;
        fill_d    = fill_q;
        wptr_d    = wptr_q;
        loss_d    = loss_next;
        value_d   = value_q;
        update_d  = 1'b0;
        valid_d   = valid_q;
        timeout_d = timeout_q;
        flush     = 1'b0;

        if (i_clear) begin
            flush     = 1'b1;
            timeout_d = 1'b0;
            state_d   = ST_FILLING;
        end else if (touch) begin
            loss_d    = '0;
            timeout_d = 1'b0;
            if (state_q == ST_LOST) begin
                state_d = ST_FILLING;
            end
            if (accept) begin
                ring_d[wptr_q] = i_capture_value;
                sum_d          = sum_new;
                wptr_d         = (wptr_q == WPTR_LAST) ? '0 : wptr_q + PW'(1);
                fill_d         = fill_new;
                value_d        = sum_shift[K_DWIDTH-1:0];
                update_d       = 1'b1;
                valid_d        = (fill_new == FILL_FULL);
                state_d        = (fill_new == FILL_FULL) ? ST_FULL : ST_FILLING;
            end
        end else if (loss_hit) begin
            flush     = 1'b1;
            timeout_d = 1'b1;
            state_d   = ST_LOST;
        end

        if (flush) begin
            ring_d  = '{default: '0};
            sum_d   = '0;
            fill_d  = '0;
            wptr_d  = '0;
            loss_d  = '0;
            value_d = '0;
            valid_d = 1'b0;
        end
    end

    // State, storage and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_FILLING;
            ring_q    <= '{default: '0};
            sum_q     <= '0;
            fill_q    <= '0;
            wptr_q    <= '0;
            loss_q    <= '0;
            value_q   <= '0;
            update_q  <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ring_q    <= ring_d;
            sum_q     <= sum_d;
            fill_q    <= fill_d;
            wptr_q    <= wptr_d;
            loss_q    <= loss_d;
            value_q   <= value_d;
            update_q  <= update_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_value   = value_q;
    assign o_update  = update_q;
    assign o_valid   = valid_q;
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_pwm_capture_average.sv
// Directed bench for pwm_capture_average at default parameters (D=4, 16-bit).
module tb_pwm_capture_average;

    logic        clk;
    logic        rst_n;
    logic        timebase;
    logic        cap_done;
    logic [15:0] cap_value;
    logic [15:0] timeout_thr;
    logic        clear;
    logic [15:0] value;
    logic        update;
    logic        valid;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    pwm_capture_average #(.K_DWIDTH(16), .K_LOG2_DEPTH(2)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_timebase      (timebase),
        .i_capture_done  (cap_done),
        .i_capture_value (cap_value),
        .i_timeout       (timeout_thr),
        .i_clear         (clear),
        .o_value         (value),
        .o_update        (update),
        .o_valid         (valid),
        .o_timeout       (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One capture pulse. Outputs are checked 1ns after the edge that sampled it.
    task automatic cap(input logic [15:0] v, input logic [15:0] exp_val, input logic exp_valid, input string tag);
        @(negedge clk);
        cap_done  = 1'b1;
        cap_value = v;
        @(posedge clk);
        #1;
        cap_done = 1'b0;
        check_val({tag, "_update"}, update, 1);
        check_val({tag, "_value"},  value,  exp_val);
        check_val({tag, "_valid"},  valid,  exp_valid);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            timebase = 1'b1;
            @(posedge clk);
            #1;
            timebase = 1'b0;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        timebase    = 1'b0;
        cap_done    = 1'b0;
        cap_value   = '0;
        timeout_thr = '0;
        clear       = 1'b0;
        #23;
        check_val("rst_value",   value,   0);
        check_val("rst_update",  update,  0);
        check_val("rst_valid",   valid,   0);
        check_val("rst_timeout", timeout, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill the buffer back to back with timeout disabled.
        cap(16'd100, 16'd25,  1'b0, "fill1");
        cap(16'd200, 16'd75,  1'b0, "fill2");
        cap(16'd300, 16'd150, 1'b0, "fill3");
        cap(16'd400, 16'd250, 1'b1, "fill4");
        idle(1);
        check_val("update_one_cycle", update, 0);
        check_val("hold_value", value, 250);
        cap(16'd500, 16'd350, 1'b1, "wrap5");

        // Saturated capture on a full buffer.
`ifdef PWM_AVG_DROP_SATURATED_EN
        @(negedge clk);
        cap_done  = 1'b1;
        cap_value = 16'hFFFF;
        @(posedge clk);
        #1;
        cap_done = 1'b0;
        check_val("sat_drop_update", update, 0);
        check_val("sat_drop_value",  value,  350);
        check_val("sat_drop_valid",  valid,  1);
`else
        cap(16'hFFFF, 16'd16683, 1'b1, "sat_accept");
`endif

        // A clear beats a simultaneous capture.
        @(negedge clk);
        clear     = 1'b1;
        cap_done  = 1'b1;
        cap_value = 16'd999;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        cap_done = 1'b0;
        check_val("clr_update",  update,  0);
        check_val("clr_value",   value,   0);
        check_val("clr_valid",   valid,   0);
        check_val("clr_timeout", timeout, 0);

        // Loss detection with threshold 10.
        timeout_thr = 16'd10;
        cap(16'd80, 16'd20, 1'b0, "pre_loss1");
        cap(16'd80, 16'd40, 1'b0, "pre_loss2");
        ticks(9);
        check_val("loss_tick9", timeout, 0);
        ticks(1);
        check_val("loss_tick10", timeout, 1);
        check_val("loss_value",  value,   0);
        check_val("loss_valid",  valid,   0);
        ticks(12);
        check_val("lost_sticky", timeout, 1);
        cap(16'd80, 16'd20, 1'b0, "recover");
        check_val("recover_timeout", timeout, 0);

        // A capture in the same cycle as the 10th tick wins, and the counter restarts.
        ticks(9);
        @(negedge clk);
        timebase  = 1'b1;
        cap_done  = 1'b1;
        cap_value = 16'd80;
        @(posedge clk);
        #1;
        timebase = 1'b0;
        cap_done = 1'b0;
        check_val("coinc_timeout", timeout, 0);
        check_val("coinc_update",  update,  1);
        check_val("coinc_value",   value,   40);
        ticks(9);
        check_val("restart_tick9", timeout, 0);
        ticks(1);
        check_val("restart_tick10", timeout, 1);

        // Asynchronous reset mid-fill, then a back-to-back refill.
        timeout_thr = 16'd0;
        cap(16'd40, 16'd10, 1'b0, "pre_rst1");
        cap(16'd40, 16'd20, 1'b0, "pre_rst2");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_value",   value,   0);
        check_val("arst_update",  update,  0);
        check_val("arst_valid",   valid,   0);
        check_val("arst_timeout", timeout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cap(16'd40, 16'd10, 1'b0, "refill1");
        cap(16'd40, 16'd20, 1'b0, "refill2");
        cap(16'd40, 16'd30, 1'b0, "refill3");
        cap(16'd40, 16'd40, 1'b1, "refill4");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
